nios_ii_mul_seq: RTL

- Sequencer that time-shares one registered 16x16 unsigned multiplier cell to produce the full 64-bit product of two 32-bit operands.
- Supports the Nios II multiply forms mul, mulxss, mulxsu and mulxuu.
- Sits beside the CPU execute stage as a low-area alternative to the three-cell parallel multiplier, for Cyclone 10 LP builds that are short on DSP blocks.
- Uses a valid/ready handshake on both the command side and the result side.

---
 rtl/nios_ii_mul_pkg.sv | 28 ++
 rtl/nios_ii_mul_seq_cell.sv | 58 +++++
 rtl/nios_ii_mul_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/nios_ii_mul_pkg.sv
// Shared constants for the sequential Nios II multiplier: op codes, FSM
// state encoding and the partial-product shift table.
package nios_ii_mul_pkg;

  localparam logic [1:0] MUL_OP_MUL = 2'd0;
  localparam logic [1:0] MUL_OP_XSS = 2'd1;
  localparam logic [1:0] MUL_OP_XSU = 2'd2;
  localparam logic [1:0] MUL_OP_XUU = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_CORR  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Tag encodes which 16-bit halves were multiplied: {a_hi, b_hi}.
  function automatic logic [5:0] pp_shift(input logic [1:0] tag);
    logic [5:0] sh;
    case (tag)
      2'd0:    sh = 6'd0;
      2'd1:    sh = 6'd16;
      2'd2:    sh = 6'd16;
      default: sh = 6'd32;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/nios_ii_mul_seq_cell.sv
// Registered 16x16 unsigned multiplier with enable, synchronous clear and a
// valid/tag side pipeline of MUL_LATENCY stages.
module nios_ii_mul_seq_cell #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        in_vld,
  input  logic [1:0]  in_tag,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_vld,
  output logic [1:0]  out_tag,
  output logic [31:0] p
);

  logic [31:0] prod_q [MUL_LATENCY];
  logic [31:0] prod_d [MUL_LATENCY];
  logic [1:0]  tag_q  [MUL_LATENCY];
  logic [1:0]  tag_d  [MUL_LATENCY];
  logic [MUL_LATENCY-1:0] vld_q;
  logic [MUL_LATENCY-1:0] vld_d;

  always_comb begin
    prod_d = prod_q;
    tag_d  = tag_q;
    vld_d  = vld_q;
    if (en) begin
      prod_d[0] = 32'(a) * 32'(b);
      tag_d[0]  = in_tag;
      vld_d[0]  = in_vld;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        prod_d[i] = prod_q[i-1];
        tag_d[i]  = tag_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
    end
    if (clr) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        prod_d[i] = '0;
        tag_d[i]  = '0;
      end
      vld_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    tag_q  <= tag_d;
    vld_q  <= vld_d;
  end

  assign p       = prod_q[MUL_LATENCY-1];
  assign out_tag = tag_q[MUL_LATENCY-1];
  assign out_vld = vld_q[MUL_LATENCY-1];

endmodule

// File: rtl/nios_ii_mul_seq.sv
// Sequential 32x32->64 multiplier for Nios II mul/mulxss/mulxsu/mulxuu built
// around one shared 16x16 cell; four partial products, then signed fix-up.
module nios_ii_mul_seq
  import nios_ii_mul_pkg::*;
#(
  parameter int MUL_LATENCY = 1,
  parameter bit RESULT_HOLD = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [1:0]  cmd_op,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_lo,
  output logic [31:0] res_hi,
  output logic        busy
);

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  drain_q, drain_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;

  logic        cell_clr;
  logic        cell_en;
  logic [15:0] cell_a;
  logic [15:0] cell_b;
  logic        cell_out_vld;
  logic [1:0]  cell_out_tag;
  logic [31:0] cell_p;
  logic [31:0] corr;

  // cnt[1] selects the high half of A, cnt[0] the high half of B.
  assign cell_a  = cnt_q[1] ? a_q[31:16] : a_q[15:0];
  assign cell_b  = cnt_q[0] ? b_q[31:16] : b_q[15:0];
  assign cell_en = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);

  nios_ii_mul_seq_cell #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_cell (
    .clk     (clk),
    .clr     (cell_clr),
    .en      (cell_en),
    .in_vld  (state_q == ST_ISSUE),
    .in_tag  (cnt_q),
    .a       (cell_a),
    .b       (cell_b),
    .out_vld (cell_out_vld),
    .out_tag (cell_out_tag),
    .p       (cell_p)
  );

  // Unsigned product minus the sign-weight terms gives the signed high word.
  always_comb begin
    corr = '0;
    case (op_q)
      MUL_OP_XSS: corr = (a_q[31] ? b_q : 32'd0) + (b_q[31] ? a_q : 32'd0);
      MUL_OP_XSU: corr = a_q[31] ? b_q : 32'd0;
      MUL_OP_XUU: corr = '0;
      MUL_OP_MUL: corr = '0;
      default:    corr = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cell_clr = ~reset_n;

    if (cell_en && cell_out_vld) begin
      acc_d = acc_q + (64'(cell_p) << pp_shift(cell_out_tag));
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          a_d      = cmd_a;
          b_d      = cmd_b;
          op_d     = cmd_op;
          acc_d    = '0;
          cnt_d    = '0;
          cell_clr = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          drain_d = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(MUL_LATENCY - 1)) begin
          state_d = ST_CORR;
        end
      end
      ST_CORR: begin
        acc_d[63:32] = acc_q[63:32] - corr;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        if (!RESULT_HOLD || res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      acc_q   <= '0;
      op_q    <= MUL_OP_MUL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign cmd_ready = reset_n && (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_lo    = acc_q[31:0];
  assign res_hi    = acc_q[63:32];
  assign busy      = (state_q != ST_IDLE);

endmodule
